// File: rtl/b2oc_pkg.sv
// Shared types and constants for the Block 2 output collector.
package b2oc_pkg;

    localparam int CH       = 16;               // channels per cycle, one bank each
    localparam int WORD_W   = 32;               // bits per buffer word
    localparam int DEPTH    = 32;               // words per bank
    localparam int ADDR_W   = $clog2(DEPTH);    // word address width
    localparam int BIT_W    = $clog2(WORD_W);   // bit position inside a word
    localparam int FILL_W   = BIT_W + 1;        // 1..WORD_W valid bits in a word
    localparam int POPCNT_W = 11;               // per-channel ones count (frames up to 2047 bits)

    typedef enum logic [1:0] {
        ACC   = 2'd0,   // accepting bits
        FLUSH = 2'd1,   // trailing partial word on the bus
        HOLD  = 2'd2    // buffer owned by downstream
    } state_t;

endpackage

// File: rtl/b2oc_lane.sv
// One channel lane: MSB-first shift register, left-align pad shifter and,
// when B2OC_POPCOUNT_EN is defined, a count of ones seen in the current frame.
module b2oc_lane
    import b2oc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,      // synchronous, active-high
    input  logic                clr,        // frame released, start a fresh frame
    input  logic                shift_en,   // a valid bit is accepted this cycle
    input  logic                bin,
    input  logic [FILL_W-1:0]   fill,       // valid bits in word, including this one
    output logic [WORD_W-1:0]   word
`ifdef B2OC_POPCOUNT_EN
    ,
    output logic [POPCNT_W-1:0] popcnt
`endif
);

    logic [WORD_W-1:0] sh;
    logic [WORD_W-1:0] sh_next;

    // The word written always includes the bit arriving this cycle; a short
    // word is left-aligned so the zero pad lands in the LSBs.
    assign sh_next = {sh[WORD_W-2:0], bin};
    assign word    = sh_next << (FILL_W'(WORD_W) - fill);

    // Shift in accepted bits; older bits simply fall off the top.
    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every lane sees the pre-edge value of sh.
        if (rst_n || clr) begin
            sh <= '0;
        end else if (shift_en) begin
            sh <= sh_next;
        end
    end

`ifdef B2OC_POPCOUNT_EN
    // Count ones of the frame; value is meaningful from frame_done to release.
    always_ff @(posedge clk) begin
        if (rst_n || clr) begin
            popcnt <= '0;
        end else if (shift_en && bin) begin
            popcnt <= popcnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/b2_out_collector.sv
// Block 2 output collector: packs CH channel bit streams MSB-first into
// WORD_W-bit words, writes one frame into the bank buffer, then holds the
// buffer for Block 3 until frame_release.
// Optional feature macro: B2OC_POPCOUNT_EN (adds per-channel popcnt output).
module b2_out_collector
    import b2oc_pkg::*;
#(
    parameter int FRAME_BITS = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,          // synchronous, active-high
    input  logic [CH-1:0]          bin_i,
    input  logic                   bin_val,
    input  logic                   frame_release,
    output logic [CH*WORD_W-1:0]   buf_din,
    output logic [ADDR_W-1:0]      buf_addr,
    output logic                   buf_we,
    output logic                   buf_en,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   overflow
`ifdef B2OC_POPCOUNT_EN
    ,
    output logic [CH*POPCNT_W-1:0] popcnt
`endif
);

    localparam int WORDS = (FRAME_BITS + WORD_W - 1) / WORD_W;
    localparam int TOT_W = $clog2(FRAME_BITS + 1);
    localparam logic [TOT_W-1:0] LAST_CNT = TOT_W'(FRAME_BITS - 1);

    if (WORDS > DEPTH || FRAME_BITS < 1) begin : g_bad_frame
        $error("b2_out_collector: FRAME_BITS does not fit the buffer");
    end
`ifdef B2OC_POPCOUNT_EN
    if (FRAME_BITS > 2047) begin : g_bad_popcnt
        $error("b2_out_collector: FRAME_BITS too large for popcount width");
    end
`endif

    state_t              state;
    logic [BIT_W-1:0]    bit_cnt;
    logic [TOT_W-1:0]    total_cnt;
    logic [ADDR_W-1:0]   word_addr;
    logic                done_pend;     // entered HOLD straight from ACC

    logic                accept;
    logic                word_full;
    logic                last_bit;
    logic                lane_clr;
    logic [FILL_W-1:0]   fill;
    logic [CH*WORD_W-1:0] lane_bus;

    assign accept    = (state == ACC) && bin_val;
    assign word_full = (bit_cnt == BIT_W'(WORD_W - 1));
    assign last_bit  = (total_cnt == LAST_CNT);
    assign lane_clr  = (state == HOLD) && frame_release;
    assign fill      = {1'b0, bit_cnt} + 1'b1;

    for (genvar k = 0; k < CH; k++) begin : g_lane
        b2oc_lane u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (lane_clr),
            .shift_en (accept),
            .bin      (bin_i[k]),
            .fill     (fill),
            .word     (lane_bus[k*WORD_W +: WORD_W])
`ifdef B2OC_POPCOUNT_EN
            ,
            .popcnt   (popcnt[k*POPCNT_W +: POPCNT_W])
`endif
        );
    end

    // Frame FSM with counters and registered buffer/status outputs. The
    // trailing partial word is registered on the way into FLUSH, so it is on
    // the bus during FLUSH and frame_done follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= ACC;
            bit_cnt    <= '0;
            total_cnt  <= '0;
            word_addr  <= '0;
            done_pend  <= 1'b0;
            buf_din    <= '0;
            buf_addr   <= '0;
            buf_we     <= 1'b0;
            buf_en     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            buf_we     <= 1'b0;
            buf_en     <= 1'b0;
            frame_done <= 1'b0;
            if (bin_val && state != ACC) begin
                overflow <= 1'b1;
            end
            unique case (state)
                ACC: begin
                    if (bin_val) begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        total_cnt <= total_cnt + 1'b1;
                        if (word_full || last_bit) begin
                            buf_we    <= 1'b1;
                            buf_en    <= 1'b1;
                            buf_addr  <= word_addr;
                            buf_din   <= lane_bus;
                            word_addr <= word_addr + 1'b1;
                        end
                        if (last_bit) begin
                            if (word_full) begin
                                state     <= HOLD;
                                done_pend <= 1'b1;
                            end else begin
                                state <= FLUSH;
                                busy  <= 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    state      <= HOLD;
                    frame_done <= 1'b1;
                end
                HOLD: begin
                    done_pend <= 1'b0;
                    if (done_pend) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b1;
                    end
                    if (frame_release) begin
                        state     <= ACC;
                        busy      <= 1'b0;
                        bit_cnt   <= '0;
                        total_cnt <= '0;
                        word_addr <= '0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
